iso14443a_app_tx_arbiter: RTL and testbench

Application-side transmit controller between one or more application reply sources and the ISO/IEC 14443-4A core's byte-wide transmit path. It grants the transmit path to one source per reply message using round-robin arbitration at message boundaries, and records each forwarded reply in a local buffer. When the core asserts its resend-last request, the block replays the recorded reply autonomously, so sources need no replay logic.

---
 rtl/iso14443a_app_tx_arbiter.sv | 178 +++++++++++++++++
 tb/tb_iso14443a_app_tx_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iso14443a_app_tx_arbiter.sv
// Round-robin message arbiter in front of the 14443-4A transmit path.
// Records each forwarded reply so a resend request can be replayed without source involvement.
module iso14443a_app_tx_arbiter #(
    parameter int NUM_SRC   = 2,
    parameter int BUF_DEPTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [NUM_SRC*8-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_last,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic [NUM_SRC-1:0]   src_grant,
    input  logic                 resend_last,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_last,
    input  logic                 tx_ready,
    output logic                 replay_active,
    output logic                 buf_valid,
    output logic                 overflow
);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PTR_W = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_REPLAY} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   rr_last_q;
    logic               pending_q;
    logic [PTR_W:0]     wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W:0]     len_q;
    logic               ovf_q;
    logic               buf_valid_q;
    logic               overflow_q;
    logic [7:0]         mem_q [BUF_DEPTH];

    logic               sel_valid, sel_last;
    logic [7:0]         sel_data;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    int                 cand_i;
    logic               xfer, wr_full, ovf_next, replay_last, resend_any;

    assign sel_valid   = src_valid[grant_q];
    assign sel_last    = src_last[grant_q];
    assign sel_data    = src_data[{grant_q, 3'b000} +: 8];
    assign xfer        = tx_valid & tx_ready;
    assign wr_full     = (wr_ptr_q == (PTR_W+1)'(BUF_DEPTH));
    assign ovf_next    = ovf_q | wr_full;
    assign replay_last = ({1'b0, rd_ptr_q} == len_q - 1'b1);
    assign resend_any  = resend_last | pending_q;
    assign buf_valid   = buf_valid_q;
    assign overflow    = overflow_q;

    // Search begins one past the source that completed the previous message.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_i    = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand_i = (int'(rr_last_q) + 1 + k) % NUM_SRC;
            if (!win_found && src_valid[cand_i[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand_i[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (resend_any && buf_valid_q) begin
                    state_d = ST_REPLAY;
                end else if (win_found) begin
                    state_d = ST_PASS;
                end
            end
            ST_PASS:   if (xfer && sel_last)    state_d = ST_IDLE;
            ST_REPLAY: if (xfer && replay_last) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        tx_last       = 1'b0;
        src_grant     = '0;
        src_ready     = '0;
        replay_active = 1'b0;
        case (state_q)
            ST_PASS: begin
                tx_valid  = sel_valid;
                tx_data   = sel_data;
                tx_last   = sel_last;
                src_grant = NUM_SRC'(1) << grant_q;
                src_ready = (NUM_SRC'(1) << grant_q) & {NUM_SRC{tx_ready}};
            end
            ST_REPLAY: begin
                tx_valid      = 1'b1;
                tx_data       = mem_q[rd_ptr_q];
                tx_last       = replay_last;
                replay_active = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q     <= '0;
            rr_last_q   <= IDX_W'(NUM_SRC - 1);
            pending_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            buf_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            // IDLE always consumes the request: either it starts a replay or it is dropped.
            pending_q <= (state_q == ST_IDLE) ? 1'b0 : (pending_q | resend_last);
            case (state_q)
                ST_IDLE: begin
                    if (state_d == ST_PASS) begin
                        grant_q     <= win_idx;
                        buf_valid_q <= 1'b0;
                        overflow_q  <= 1'b0;
                        wr_ptr_q    <= '0;
                        ovf_q       <= 1'b0;
                    end
                    if (state_d == ST_REPLAY) begin
                        rd_ptr_q <= '0;
                    end
                end
                ST_PASS: begin
                    if (xfer) begin
                        if (wr_full) begin
                            ovf_q <= 1'b1;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                        if (sel_last) begin
                            len_q       <= wr_full ? wr_ptr_q : wr_ptr_q + 1'b1;
                            buf_valid_q <= !ovf_next;
                            overflow_q  <= ovf_next;
                            rr_last_q   <= grant_q;
                        end
                    end
                end
                ST_REPLAY: begin
                    if (xfer) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_PASS && xfer && !wr_full) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= tx_data;
        end
    end
endmodule

// File: tb/tb_iso14443a_app_tx_arbiter.sv
// Randomized scoreboard bench: stimulus pushes the expected byte stream, a monitor pops and compares on every transfer.
module tb_iso14443a_app_tx_arbiter;
    localparam int NS = 3;
    localparam int BD = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NS-1:0]   src_valid = '0;
    logic [NS*8-1:0] src_data = '0;
    logic [NS-1:0]   src_last = '0;
    logic [NS-1:0]   src_ready, src_grant;
    logic            resend_last = 1'b0;
    logic            tx_valid, tx_last, tx_ready = 1'b0;
    logic [7:0]      tx_data;
    logic            replay_active, buf_valid, overflow;

    iso14443a_app_tx_arbiter #(.NUM_SRC(NS), .BUF_DEPTH(BD)) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
        .src_ready(src_ready), .src_grant(src_grant),
        .resend_last(resend_last),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
        .replay_active(replay_active), .buf_valid(buf_valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         src;   // -1 marks a replayed byte
        int         at;    // expected cycle of the transfer, -1 if not timed
    } exp_t;

    exp_t          exp_q[$];
    logic [8:0]    sq[NS][$];
    logic [7:0]    pend[NS][$];
    logic [NS-1:0] acc = '0;
    logic [NS-1:0] mid = '0;
    bit            rdy_mode = 1'b1;
    bit            gap_en = 1'b0;
    int            vectors = 0;
    int            errors = 0;

    // Reference model state: last complete reply, validity, round-robin history
    logic [7:0]    mbuf[$];
    bit            mbv = 1'b0;
    bit            movf = 1'b0;
    int            rr_last = NS - 1;
    bit            timed = 1'b0;
    int            tnext = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    exp_t          cur;
    logic [NS-1:0] oh;
    always @(negedge clk) begin
        acc <= src_valid & src_ready;
        if (!rst && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_xfer: got data %02h last %0b, required no transfer (cycle %0d)",
                         tx_data, tx_last, cyc);
            end else begin
                cur = exp_q.pop_front();
                oh  = (cur.src < 0) ? '0 : (NS'(1) << cur.src);
                chk("tx_data", 32'(tx_data), 32'(cur.data));
                chk("tx_last", 32'(tx_last), 32'(cur.last));
                chk("replay_active", 32'(replay_active), 32'(cur.src < 0));
                chk("src_grant", 32'(src_grant), 32'(oh));
                chk("src_ready", 32'(src_ready), 32'(oh));
                if (cur.at >= 0) chk("xfer_cycle", 32'(cyc), 32'(cur.at));
            end
        end
    end

    // Source and sink driver: sources hold a byte until accepted and may pause between bytes.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int s = 0; s < NS; s++) begin
                if (acc[s] && sq[s].size() > 0) begin
                    mid[s] = !sq[s][0][8];
                    void'(sq[s].pop_front());
                end
                if (sq[s].size() == 0) begin
                    src_valid[s] = 1'b0;
                end else if (acc[s] || !src_valid[s]) begin
                    src_valid[s]         = !mid[s] || !gap_en || ($urandom_range(0, 1) == 1);
                    src_data[8*s +: 8]   = sq[s][0][7:0];
                    src_last[s]          = sq[s][0][8];
                end
            end
            tx_ready = rdy_mode ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
    end

    function automatic bit sq_empty();
        for (int s = 0; s < NS; s++) if (sq[s].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic flush();
        exp_q.delete();
        for (int s = 0; s < NS; s++) sq[s].delete();
        mid = '0;
    endtask

    task automatic gen(int s, int len);
        pend[s].delete();
        for (int i = 0; i < len; i++) pend[s].push_back(8'($urandom));
    endtask

    function automatic int rand_len();
        case ($urandom_range(0, 5))
            0: return 1;
            1: return BD;
            2: return BD + 1;
            3: return BD - 1;
            default: return $urandom_range(2, BD + 3);
        endcase
    endfunction

    task automatic model_send(int s);
        exp_t e;
        int   n = pend[s].size();
        for (int i = 0; i < n; i++) begin
            e.data = pend[s][i];
            e.last = (i == n - 1);
            e.src  = s;
            e.at   = timed ? tnext + i : -1;
            exp_q.push_back(e);
        end
        tnext = tnext + n + 1;
        if (n > BD) begin
            mbv  = 1'b0;
            movf = 1'b1;
        end else begin
            mbuf = pend[s];
            mbv  = 1'b1;
            movf = 1'b0;
        end
        rr_last = s;
    endtask

    task automatic model_replay();
        exp_t e;
        if (!mbv) return;
        for (int i = 0; i < mbuf.size(); i++) begin
            e.data = mbuf[i];
            e.last = (i == mbuf.size() - 1);
            e.src  = -1;
            e.at   = timed ? tnext + i : -1;
            exp_q.push_back(e);
        end
        tnext = tnext + mbuf.size() + 1;
    endtask

    // Messages from all sources in mask, served one by one in rotating order.
    task automatic model_rr(logic [NS-1:0] mask);
        logic [NS-1:0] m = mask;
        while (m != '0) begin
            for (int k = 1; k <= NS; k++) begin
                int s = (rr_last + k) % NS;
                if (m[s]) begin
                    model_send(s);
                    m[s] = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic load(logic [NS-1:0] mask);
        for (int s = 0; s < NS; s++) begin
            if (mask[s]) begin
                for (int i = 0; i < pend[s].size(); i++)
                    sq[s].push_back({(i == pend[s].size() - 1), pend[s][i]});
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        bit done = 1'b0;
        while (!done) begin
            @(negedge clk);
            n++;
            done = (exp_q.size() == 0) && sq_empty() && !tx_valid && (src_grant == '0)
                   && !replay_active && !resend_last;
            if (!done && n > 4000) begin
                vectors++;
                errors++;
                $display("FAIL idle_timeout: got %0d pending bytes, required 0 (cycle %0d)", exp_q.size(), cyc);
                flush();
                done = 1'b1;
            end
        end
        chk("buf_valid", 32'(buf_valid), 32'(mbv));
        chk("overflow", 32'(overflow), 32'(movf));
    endtask

    task automatic phase_a(logic [NS-1:0] mask);
        timed = rdy_mode;
        tnext = cyc + 2;
        for (int s = 0; s < NS; s++) if (mask[s]) gen(s, rand_len());
        model_rr(mask);
        load(mask);
        wait_idle();
    endtask

    task automatic resend_idle();
        timed = rdy_mode;
        tnext = cyc + 1;
        resend_last = 1'b1;
        model_replay();
        @(posedge clk);
        #1 resend_last = 1'b0;
        wait_idle();
    endtask

    // Resend arrives while source s is granted; late sources queue up behind the replay.
    task automatic pass_resend(int s, logic [NS-1:0] late);
        int n = 0;
        timed = 1'b0;
        gen(s, rand_len());
        for (int j = 0; j < NS; j++) if (late[j]) gen(j, rand_len());
        model_send(s);
        model_replay();
        model_rr(late);
        load(NS'(1) << s);
        while (!src_grant[s] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("grant_seen", 32'(src_grant[s]), 32'd1);
        resend_last = 1'b1;
        load(late);
        @(posedge clk);
        #1 resend_last = 1'b0;
        wait_idle();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tx_last", 32'(tx_last), 32'd0);
        chk("rst_src_grant", 32'(src_grant), 32'd0);
        chk("rst_src_ready", 32'(src_ready), 32'd0);
        chk("rst_replay_active", 32'(replay_active), 32'd0);
        chk("rst_buf_valid", 32'(buf_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // Two sources at once after reset, twice: 0 first each time, one idle cycle between messages
        repeat (2) begin
            timed = 1'b1;
            tnext = cyc + 2;
            gen(0, 2);
            gen(1, 3);
            model_rr(3'b011);
            load(3'b011);
            wait_idle();
        end

        // Three-byte reply, then two identical replays
        timed = 1'b1;
        tnext = cyc + 2;
        pend[0].delete();
        pend[0].push_back(8'hA1);
        pend[0].push_back(8'hB2);
        pend[0].push_back(8'hC3);
        model_send(0);
        load(3'b001);
        wait_idle();
        resend_idle();
        resend_idle();

        // One byte past the buffer: forwarded, flagged, not replayable
        timed = 1'b1;
        tnext = cyc + 2;
        gen(2, BD + 1);
        model_send(2);
        load(3'b100);
        wait_idle();
        resend_idle();
        repeat (4) begin
            @(negedge clk);
            chk("dropped_resend", 32'(tx_valid), 32'd0);
        end

        // Exactly full buffer is still replayable
        timed = 1'b1;
        tnext = cyc + 2;
        gen(1, BD);
        model_send(1);
        load(3'b010);
        wait_idle();
        resend_idle();

        // Resend during source 1's message with a stalling sink, source 0 waiting
        rdy_mode = 1'b0;
        pass_resend(1, 3'b001);

        gap_en = 1'b1;
        repeat (40) begin
            if ($urandom_range(0, 2) == 0) begin
                int s = $urandom_range(0, NS - 1);
                logic [NS-1:0] late = NS'($urandom_range(0, (1 << NS) - 1));
                late[s] = 1'b0;
                pass_resend(s, late);
            end else begin
                phase_a(NS'($urandom_range(1, (1 << NS) - 1)));
            end
            if ($urandom_range(0, 1) == 1) resend_idle();
        end

        // Reset in the middle of a replay
        rdy_mode = 1'b1;
        gap_en = 1'b0;
        timed = 1'b1;
        tnext = cyc + 2;
        gen(0, 4);
        model_send(0);
        load(3'b001);
        wait_idle();
        timed = 1'b0;
        resend_last = 1'b1;
        model_replay();
        @(posedge clk);
        #1 resend_last = 1'b0;
        @(negedge clk);
        chk("replay_started", 32'(replay_active), 32'd1);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        flush();
        mbv = 1'b0;
        movf = 1'b0;
        rr_last = NS - 1;
        @(negedge clk);
        chk("abort_tx_valid", 32'(tx_valid), 32'd0);
        chk("abort_buf_valid", 32'(buf_valid), 32'd0);
        chk("abort_replay_active", 32'(replay_active), 32'd0);
        resend_last = 1'b1;
        @(posedge clk);
        #1 resend_last = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_resend", 32'(tx_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
